// File: rtl/div_seq_ctrl.sv
// Sequencer between ALU-control decode and the unsigned multicycle divider core.
// Feeds magnitudes to the core, applies MIPS sign rules and commits HI/LO.
module div_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] dv_a,
  output logic [WIDTH-1:0] dv_b,
  output logic             dv_init,
  input  logic             dv_stop,
  input  logic             dv_zero,
  input  logic [WIDTH-1:0] dv_rem,
  input  logic [WIDTH-1:0] dv_quo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero_exc,
  output logic             timeout_exc
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RUN, FIX, WRITE, ERR, DRAIN} state_t;

  state_t state, next_state;

  logic             sa, sb, sa_d, sb_d;
  logic [WIDTH-1:0] quo_r, rem_r, quo_d, rem_d;
  logic [WIDTH-1:0] dv_a_d, dv_b_d, hi_d, lo_d;
  logic [WD_W-1:0]  wd, wd_d;
  logic             dv_init_d, busy_d, done_d, zexc_d, texc_d;
  logic             timeout_hit;

  // True on the RUN cycle whose increment makes the watchdog reach TIMEOUT.
  assign timeout_hit = (wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN: begin
        if (dv_zero)          next_state = ERR;
        else if (dv_stop)     next_state = FIX;
        else if (timeout_hit) next_state = ERR;
      end
      FIX:     next_state = WRITE;
      WRITE:   next_state = DRAIN;
      ERR:     next_state = DRAIN;
      DRAIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sa_d   = sa;
    sb_d   = sb;
    quo_d  = quo_r;
    rem_d  = rem_r;
    dv_a_d = dv_a;
    dv_b_d = dv_b;
    hi_d   = hi_out;
    lo_d   = lo_out;
    wd_d   = wd;
    done_d = 1'b0;
    zexc_d = 1'b0;
    texc_d = 1'b0;
    case (state)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          sa_d   = is_signed & op_a[WIDTH-1];
          sb_d   = is_signed & op_b[WIDTH-1];
          dv_a_d = (is_signed & op_a[WIDTH-1]) ? -op_a : op_a;
          dv_b_d = (is_signed & op_b[WIDTH-1]) ? -op_b : op_b;
          wd_d   = '0;
        end
      end
      RUN: begin
        wd_d   = wd + WD_W'(1);
        zexc_d = dv_zero;
        texc_d = !dv_zero && !dv_stop && timeout_hit;
        if (!dv_zero && dv_stop) begin
          quo_d = dv_quo;
          rem_d = dv_rem;
        end
      end
      // Remainder follows the dividend's sign; quotient is negative on sign mismatch.
      FIX: begin
        quo_d = (sa ^ sb) ? -quo_r : quo_r;
        rem_d = sa ? -rem_r : rem_r;
      end
      WRITE: begin
        hi_d   = rem_r;
        lo_d   = quo_r;
        done_d = 1'b1;
      end
      default: ;
    endcase
    // dv_init drops only in DRAIN so the core can clear its finished state.
    dv_init_d = (next_state == RUN) || (next_state == FIX) ||
                (next_state == WRITE) || (next_state == ERR);
    busy_d    = (next_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa           <= 1'b0;
      sb           <= 1'b0;
      quo_r        <= '0;
      rem_r        <= '0;
      dv_a         <= '0;
      dv_b         <= '0;
      hi_out       <= '0;
      lo_out       <= '0;
      wd           <= '0;
      dv_init      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_exc  <= 1'b0;
    end else begin
      sa           <= sa_d;
      sb           <= sb_d;
      quo_r        <= quo_d;
      rem_r        <= rem_d;
      dv_a         <= dv_a_d;
      dv_b         <= dv_b_d;
      hi_out       <= hi_d;
      lo_out       <= lo_d;
      wd           <= wd_d;
      dv_init      <= dv_init_d;
      busy         <= busy_d;
      done         <= done_d;
      div_zero_exc <= zexc_d;
      timeout_exc  <= texc_d;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: behavioural 33-cycle divider core, directed table,
// hand-written corner sequences and random vectors against a signed reference.
module tb_div_seq_ctrl;
  localparam int WIDTH       = 32;
  localparam int TIMEOUT     = 40;
  localparam int CORE_CYCLES = 33;
  localparam int LATENCY     = CORE_CYCLES + 4;

  logic clk = 1'b0;
  logic reset, start, is_signed, hi_we, lo_we;
  logic [WIDTH-1:0] op_a, op_b, wdata;
  logic [WIDTH-1:0] dv_a, dv_b, dv_rem, dv_quo, hi_out, lo_out;
  logic dv_init, dv_stop, dv_zero, busy, done, div_zero_exc, timeout_exc;

  int total = 0;
  int bad   = 0;
  bit core_hang = 1'b0;
  int core_cnt;

  div_seq_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .dv_a(dv_a), .dv_b(dv_b), .dv_init(dv_init), .dv_stop(dv_stop),
    .dv_zero(dv_zero), .dv_rem(dv_rem), .dv_quo(dv_quo),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .timeout_exc(timeout_exc)
  );

  always #5 clk = ~clk;

  // Divider core model: result appears after dv_init has been high for 33 edges.
  always @(posedge clk) begin
    if (!dv_init) begin
      core_cnt <= 0;
      dv_stop  <= 1'b0;
      dv_zero  <= 1'b0;
      dv_quo   <= '0;
      dv_rem   <= '0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (dv_b == 0) dv_zero <= 1'b1;
      else if (!core_hang && core_cnt == CORE_CYCLES - 1) begin
        dv_stop <= 1'b1;
        dv_quo  <= dv_a / dv_b;
        dv_rem  <= dv_a % dv_b;
      end
    end
  end

  typedef struct {
    bit          sgn;
    logic [31:0] a, b;
    logic [31:0] exp_lo, exp_hi, exp_dva, exp_dvb;
  } vec_t;

  vec_t vecs[6];

  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint la, lb;
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = 32'(la / lb);
    r = 32'(la % lb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic waitEvent(inout int n);
    while (!(done || div_zero_exc || timeout_exc) && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                               output int n, output logic [31:0] dva1,
                               output logic [31:0] dvb1, output logic busy1);
    is_signed = sgn; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    dva1 = dv_a; dvb1 = dv_b; busy1 = busy;
    waitEvent(n);
  endtask

  initial begin
    int n;
    logic [31:0] dva1, dvb1, q, r, hi0, lo0;
    logic busy1;
    bit sgn;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          32'd100,        32'd7};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   32'd7,          32'd2};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          32'd7,          32'd2};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          32'h80000000,   32'd1};
    vecs[4] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   32'h80000000,   32'hFFFFFFFF};
    vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'd1};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) tick();
    checkOutput("reset hi", hi_out, 32'd0);
    checkOutput("reset lo", lo_out, 32'd0);
    checkOutput("reset dv_a", dv_a, 32'd0);
    checkOutput("reset dv_b", dv_b, 32'd0);
    checkOutput("reset flags", {28'd0, dv_init, busy, done, div_zero_exc | timeout_exc}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, n, dva1, dvb1, busy1);
      checkOutput($sformatf("v%0d latency", i), 32'(n), 32'(LATENCY));
      checkOutput($sformatf("v%0d lo", i), lo_out, vecs[i].exp_lo);
      checkOutput($sformatf("v%0d hi", i), hi_out, vecs[i].exp_hi);
      checkOutput($sformatf("v%0d dv_a", i), dva1, vecs[i].exp_dva);
      checkOutput($sformatf("v%0d dv_b", i), dvb1, vecs[i].exp_dvb);
      checkOutput($sformatf("v%0d busy1", i), {31'd0, busy1}, 32'd1);
      checkOutput($sformatf("v%0d exc", i), {31'd0, div_zero_exc | timeout_exc}, 32'd0);
      tick();
      checkOutput($sformatf("v%0d busy after", i), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("v%0d done pulse", i), {31'd0, done}, 32'd0);
    end

    // Divide by zero keeps preloaded HI/LO and never pulses done.
    hi_we = 1'b1; wdata = 32'hAA; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h55; tick();
    lo_we = 1'b0;
    checkOutput("mthi", hi_out, 32'hAA);
    checkOutput("mtlo", lo_out, 32'h55);
    applyStimulus(1'b1, 32'h1234, 32'd0, n, dva1, dvb1, busy1);
    checkOutput("zero exc", {31'd0, div_zero_exc}, 32'd1);
    checkOutput("zero no done", {31'd0, done}, 32'd0);
    checkOutput("zero no timeout", {31'd0, timeout_exc}, 32'd0);
    checkOutput("zero hi", hi_out, 32'hAA);
    checkOutput("zero lo", lo_out, 32'h55);
    tick();
    checkOutput("zero drain dv_init", {31'd0, dv_init}, 32'd0);
    checkOutput("zero drain busy", {31'd0, busy}, 32'd1);
    checkOutput("zero drain pulse", {31'd0, div_zero_exc | done}, 32'd0);
    tick();
    checkOutput("zero idle busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN, then a clean division.
    is_signed = 1'b0; op_a = 32'd50; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst flags", {30'd0, dv_init, busy}, 32'd0);
    checkOutput("midrst hi", hi_out, 32'd0);
    checkOutput("midrst lo", lo_out, 32'd0);
    checkOutput("midrst dv_a", dv_a, 32'd0);
    applyStimulus(1'b0, 32'd50, 32'd5, n, dva1, dvb1, busy1);
    checkOutput("postrst latency", 32'(n), 32'(LATENCY));
    checkOutput("postrst lo", lo_out, 32'd10);
    checkOutput("postrst hi", hi_out, 32'd0);
    tick();

    // MTHI/MTLO in the same cycle as start: write lands, division overwrites later.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    is_signed = 1'b0; op_a = 32'd20; op_b = 32'd6; start = 1'b1;
    tick();
    hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    checkOutput("mt+start hi", hi_out, 32'h1234);
    checkOutput("mt+start lo", lo_out, 32'h1234);
    n = 1;
    waitEvent(n);
    checkOutput("mt+start latency", 32'(n), 32'(LATENCY));
    checkOutput("mt+start q", lo_out, 32'd3);
    checkOutput("mt+start r", hi_out, 32'd2);
    tick();

    // Hung core: watchdog abort; start and MTHI/MTLO while busy are ignored.
    core_hang = 1'b1;
    hi0 = hi_out; lo0 = lo_out;
    is_signed = 1'b0; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    repeat (3) begin tick(); n++; end
    start = 1'b1; op_a = 32'd77; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
    tick(); n++;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checkOutput("busy start ignored", dv_a, 32'd9);
    checkOutput("busy mthi ignored", hi_out, hi0);
    checkOutput("busy mtlo ignored", lo_out, lo0);
    waitEvent(n);
    checkOutput("timeout exc", {31'd0, timeout_exc}, 32'd1);
    checkOutput("timeout cycle", 32'(n), 32'(TIMEOUT + 1));
    checkOutput("timeout no done", {31'd0, done | div_zero_exc}, 32'd0);
    checkOutput("timeout hi", hi_out, hi0);
    checkOutput("timeout lo", lo_out, lo0);
    tick();
    checkOutput("timeout drain busy", {31'd0, busy}, 32'd1);
    checkOutput("timeout drain dv_init", {31'd0, dv_init}, 32'd0);
    tick();
    checkOutput("timeout idle busy", {31'd0, busy}, 32'd0);
    core_hang = 1'b0;

    // Random DIV/DIVU against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom % 2);
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = $urandom_range(16, 1);
      if (i % 5 == 0) a = 32'h80000000;
      if (i % 7 == 0) b = 32'hFFFFFFFF;
      if (b == 0) b = 32'd1;
      ref_div(sgn, a, b, q, r);
      applyStimulus(sgn, a, b, n, dva1, dvb1, busy1);
      checkOutput($sformatf("rnd%0d latency", i), 32'(n), 32'(LATENCY));
      checkOutput($sformatf("rnd%0d lo", i), lo_out, q);
      checkOutput($sformatf("rnd%0d hi", i), hi_out, r);
      tick();
      checkOutput($sformatf("rnd%0d busy after", i), {31'd0, busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
